// File: rtl/buf_seq_pkg.sv
// Shared sizing constants and FSM state type for the buffer sequencer.
// Overflow flag is controlled by BUFSEQ_OVF_FLAG_EN (see buffer_seq_ctrl).
package buf_seq_pkg;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  // Count value of the last entry in a fill or drain pass.
  localparam logic [CNT_W-1:0] LAST_IDX = 4'd7;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/buffer_seq_ctrl_seq_counter.sv
// Up-counter with synchronous clear and synchronous active-low reset,
// used for both the write and the read entry counters.
module seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count register: reset and clear dominate increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/buffer_seq_ctrl.sv
// Fill/start/drain sequencer for an 8-entry buffer.
// Optional sticky overflow flag enabled by defining BUFSEQ_OVF_FLAG_EN.
module buffer_seq_ctrl
  import buf_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clear,
  input  logic              rd_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              start,
  output logic              rd_valid,
  output logic              done,
  output logic              ovf
);

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] wcnt_s;
  logic [CNT_W-1:0] rcnt_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             last_read_s;
  logic             cnt_clr_s;

  // A write is only taken in FILL; FILL exits at the 8th, so wcnt stops at 8.
  assign wr_acc_s    = (state_r == FILL) && wr_en && !clear;
  assign last_read_s = (state_r == DRAIN) && rd_ready && (rcnt_s == LAST_IDX);
  assign rd_acc_s    = (state_r == DRAIN) && rd_ready && !clear;
  assign cnt_clr_s   = clear || last_read_s;

  seq_counter #(.W(CNT_W)) u_wcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc_s),
    .clr   (cnt_clr_s),
    .cnt   (wcnt_s)
  );

  // The final handshake clears rather than increments, so rcnt never reaches 8.
  seq_counter #(.W(CNT_W)) u_rcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc_s && !last_read_s),
    .clr   (cnt_clr_s),
    .cnt   (rcnt_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state logic; clear overrides every transition.
  always_comb begin
    next_s = state_r;
    if (clear) begin
      next_s = FILL;
    end else begin
      case (state_r)
        FILL: begin
          if (wr_en && (wcnt_s == LAST_IDX)) begin
            next_s = START;
          end else begin
            next_s = FILL;
          end
        end
        START: next_s = DRAIN;
        DRAIN: begin
          if (last_read_s) begin
            next_s = FILL;
          end else begin
            next_s = DRAIN;
          end
        end
        default: next_s = FILL;
      endcase
    end
  end

  // Output decode; everything is forced low while reset is applied.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = 3'd0;
    mem_raddr = 3'd0;
    start     = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    if (rst_n) begin
      mem_we    = wr_acc_s;
      mem_waddr = wcnt_s[ADDR_W-1:0];
      mem_raddr = rcnt_s[ADDR_W-1:0];
      start     = (state_r == START) && !clear;
      rd_valid  = (state_r == DRAIN);
      done      = last_read_s && !clear;
    end else begin
      mem_we = 1'b0;
    end
  end

`ifdef BUFSEQ_OVF_FLAG_EN
  logic ovf_r;

  // Sticky flag for writes attempted while the buffer is busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (clear) begin
      ovf_r <= 1'b0;
    end else if (wr_en && (state_r != FILL)) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_seq_ctrl.sv
// Scoreboard bench for buffer_seq_ctrl: a cycle model pushes expected outputs
// per driven cycle, which are popped and compared once the DUT outputs settle.
module tb_buffer_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, clear, rd_ready;
  logic       mem_we, start, rd_valid, done, ovf;
  logic [2:0] mem_waddr, mem_raddr;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

`ifdef BUFSEQ_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic       we;
    logic [2:0] waddr;
    logic [2:0] raddr;
    logic       start;
    logic       rd_valid;
    logic       done;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: 0=FILL 1=START 2=DRAIN.
  int m_st  = 0;
  int m_w   = 0;
  int m_r   = 0;
  bit m_ovf = 1'b0;

  buffer_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .clear     (clear),
    .rd_ready  (rd_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .start     (start),
    .rd_valid  (rd_valid),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out(input bit w, input bit c, input bit r, input bit rs);
    exp_t e;
    e = '0;
    e.ovf = m_ovf;
    if (rs) begin
      e.we       = (m_st == 0) && w && !c;
      e.waddr    = 3'(m_w % 8);
      e.raddr    = 3'(m_r);
      e.start    = (m_st == 1) && !c;
      e.rd_valid = (m_st == 2);
      e.done     = (m_st == 2) && r && (m_r == 7) && !c;
    end
    return e;
  endfunction

  task automatic model_update(input bit w, input bit c, input bit r, input bit rs);
    if (!rs || c) begin
      m_st = 0; m_w = 0; m_r = 0; m_ovf = 1'b0;
    end else begin
      if (OVF_EN && w && (m_st != 0)) m_ovf = 1'b1;
      case (m_st)
        0: if (w) begin
             if (m_w == 7) m_st = 1;
             m_w++;
           end
        1: m_st = 2;
        default: if (r) begin
             if (m_r == 7) begin
               m_st = 0; m_w = 0; m_r = 0;
             end else begin
               m_r++;
             end
           end
      endcase
    end
  endtask

  task automatic step(input bit w, input bit c, input bit r, input bit rs);
    exp_t e;
    @(negedge clk);
    wr_en = w; clear = c; rd_ready = r; rst_n = rs;
    exp_q.push_back(model_out(w, c, r, rs));
    #1;
    e = exp_q.pop_front();
    check_eq("mem_we",    {3'b000, mem_we},   {3'b000, e.we});
    check_eq("mem_waddr", {1'b0, mem_waddr},  {1'b0, e.waddr});
    check_eq("mem_raddr", {1'b0, mem_raddr},  {1'b0, e.raddr});
    check_eq("start",     {3'b000, start},    {3'b000, e.start});
    check_eq("rd_valid",  {3'b000, rd_valid}, {3'b000, e.rd_valid});
    check_eq("done",      {3'b000, done},     {3'b000, e.done});
    check_eq("ovf",       {3'b000, ovf},      {3'b000, e.ovf});
    if (mem_we) we_count++;
    @(posedge clk);
    model_update(w, c, r, rs);
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    @(posedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Basic fill, start pulse, then drain with toggling rd_ready.
    fill8();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, (i % 2) == 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // wr_en held for 12 cycles from reset: only 8 accepted.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    we_count = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("we_pulses", 4'(we_count), 4'd8);
    drain_n(8);

    // Clear after five writes restarts addressing at 0.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    fill8();
    drain_n(8);

    // Clear together with the 4th read handshake; ignored write sets ovf first.
    fill8();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    drain_n(3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-drain at rcnt=3, then a full pass.
    fill8();
    drain_n(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    fill8();
    drain_n(8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_seq_ctrl.md
BUFFER_SEQ_CTRL -- requirements
Module: buffer_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset: clk and rst_n.
REQ-002 The port clk SHALL be an input, 1 bit wide, serving as the system clock; all state SHALL update on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, serving as the synchronous active-low reset.
REQ-004 The port wr_en SHALL be an input, 1 bit wide, carrying the producer's write request for one buffer entry.
REQ-005 The port clear SHALL be an input, 1 bit wide, serving as a synchronous abort that returns the block to FILL.
REQ-006 The port rd_ready SHALL be an input, 1 bit wide, indicating the consumer accepts the current read entry.
REQ-007 The port mem_we SHALL be an output, 1 bit wide, carrying the write strobe to the 8-entry buffer.
REQ-008 The port mem_waddr SHALL be an output, 3 bits wide, carrying the buffer write address.
REQ-009 The port mem_raddr SHALL be an output, 3 bits wide, carrying the buffer read address.
REQ-010 The port start SHALL be an output, 1 bit wide, carrying a one-cycle pulse when the buffer is full.
REQ-011 The port rd_valid SHALL be an output, 1 bit wide, indicating the entry at mem_raddr is offered to the consumer.
REQ-012 The port done SHALL be an output, 1 bit wide, carrying a one-cycle pulse after the 8th entry is read.
REQ-013 The port ovf SHALL be an output, 1 bit wide, carrying a sticky flag for a write attempted outside FILL.

Function
REQ-014 The FSM SHALL have exactly three states, FILL, START and DRAIN, and SHALL reset to FILL.
REQ-015 In FILL, mem_we SHALL be combinationally equal to wr_en, and mem_waddr SHALL equal wcnt[2:0].
REQ-016 The write counter wcnt SHALL be 4 bits wide, SHALL range 0..8 and SHALL increment on each accepted write.
REQ-017 When the 8th write is accepted (wcnt==7 && wr_en), the FSM SHALL go to START on the next edge and wcnt SHALL become 8.
REQ-018 START SHALL last exactly one cycle, during which start=1 and mem_we=0; the FSM SHALL then go to DRAIN.
REQ-019 In DRAIN, rd_valid SHALL be 1 and mem_raddr SHALL equal rcnt[2:0].
REQ-020 The read counter rcnt SHALL be 4 bits wide and SHALL increment only when rd_valid && rd_ready.
REQ-021 rd_valid and mem_raddr SHALL hold stable while rd_ready=0.
REQ-022 On the 8th handshake, done SHALL be 1 in that same cycle; on the next edge the FSM SHALL return to FILL with wcnt=0 and rcnt=0.
REQ-023 wr_en in START or DRAIN SHALL be ignored: mem_we=0 and no counter change.
REQ-024 The latency from the 8th accepted write to start=1 SHALL be exactly 1 cycle.
REQ-025 The latency from start=1 to the first rd_valid=1 SHALL be exactly 1 cycle.
REQ-026 A clear=1 in any state SHALL force FILL, wcnt=0 and rcnt=0 on the next edge; in that cycle mem_we=0, start=0 and done=0.
REQ-027 clear SHALL take priority over wr_en, rd_ready and FSM transitions.
REQ-028 Outputs start, done and rd_valid SHALL never be 1 in FILL.
REQ-029 The counters SHALL never wrap; values above 8 SHALL be unreachable.

Reset
REQ-030 While rst_n=0 at a clk edge, the FSM SHALL go to FILL, wcnt=0, rcnt=0 and ovf=0.
REQ-031 During reset, the outputs SHALL be mem_we=0, mem_waddr=0, mem_raddr=0, start=0, rd_valid=0 and done=0.
REQ-032 Reset SHALL take priority over clear.
REQ-033 Reset asserted mid-FILL or mid-DRAIN SHALL discard progress with no done pulse.

Configuration
REQ-034 The macro BUFSEQ_OVF_FLAG_EN SHALL control the overflow flag.
REQ-035 When BUFSEQ_OVF_FLAG_EN is defined, ovf SHALL set to 1 on any wr_en=1 in START or DRAIN and SHALL hold until reset or clear.
REQ-036 When BUFSEQ_OVF_FLAG_EN is undefined, the ovf port SHALL still exist, tied to 0, with no flag register.

Structure
REQ-037 Package buf_seq_pkg SHALL hold DEPTH=8, ADDR_W=3, CNT_W=4 and the state enum type (FILL, START, DRAIN).
REQ-038 One sub-module, seq_counter (CNT_W bits, inc/clr inputs, synchronous active-low reset), SHALL be instantiated twice, for wcnt and rcnt.

Verification
REQ-039 Reset then 8 consecutive wr_en pulses: mem_waddr SHALL step 0..7 with mem_we=1; start=1 exactly 1 cycle after the 8th write; rd_valid=1 in the following cycle.
REQ-040 DRAIN with rd_ready toggling 1,0,1,0,...: mem_raddr SHALL advance only on handshake and step 0..7; done=1 on the 8th handshake; then FILL with wcnt=0.
REQ-041 wr_en held 1 for 12 cycles from reset: exactly 8 mem_we pulses SHALL occur; with BUFSEQ_OVF_FLAG_EN ovf=1 from the cycle after the first ignored write, otherwise ovf=0 throughout.
REQ-042 clear asserted after 5 writes: the next write SHALL use mem_waddr=0 and no start pulse SHALL appear until 8 further writes.
REQ-043 clear and rd_ready asserted together on the 4th read: no done pulse, FSM SHALL be FILL, and ovf SHALL be cleared.
REQ-044 rst_n=0 for 1 cycle in mid-DRAIN (rcnt=3): all outputs SHALL be 0 after the edge, and a full 8-write/8-read cycle SHALL then complete normally.
